// File: rtl/issue_controller_if.sv
// Decoder <-> issue controller bundle: decoded fields in, issue controls out.
// master = decoder/pipeline side, slave = issue_controller.
interface issue_controller_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] srcreg1_num;
  logic [REG_W-1:0] srcreg2_num;
  logic [REG_W-1:0] dstreg_num;
  logic             using_r2;
  logic             write_reg;
  logic [2:0]       info_load;
  logic [1:0]       info_store;
  logic [2:0]       info_branch;
  logic             ex_br_taken;
  logic             id_ready;
  logic             flush;
  logic             ex_valid;
  logic [1:0]       ex_fwd1_sel;
  logic [1:0]       ex_fwd2_sel;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, srcreg1_num, srcreg2_num, dstreg_num, using_r2, write_reg,
           info_load, info_store, info_branch, ex_br_taken,
    input  id_ready, flush, ex_valid, ex_fwd1_sel, ex_fwd2_sel, stall_count
  );

  modport slave (
    input  id_valid, srcreg1_num, srcreg2_num, dstreg_num, using_r2, write_reg,
           info_load, info_store, info_branch, ex_br_taken,
    output id_ready, flush, ex_valid, ex_fwd1_sel, ex_fwd2_sel, stall_count
  );
endinterface

// File: rtl/issue_controller.sv
// Decode-to-execute issue controller for the RV32I pipeline.
// Tracks destination registers in flight in EX and MEM, detects RAW hazards and
// produces stall, flush and operand-forwarding controls.
// Build option: define FORWARDING_EN to enable forwarding (only load-use stalls);
// otherwise any EX/MEM dependency stalls and the forward selects stay at 0.
// The WB slot is not stored: the regfile is read after the WB write, so WB never
// causes a stall or a forward.
module issue_controller #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input logic          clk,
  input logic          rstd,
  issue_controller_if.slave bus
);

  // Decoder field encodings
  localparam logic [2:0] NOTLOAD   = 3'd0;
  localparam logic [1:0] NOTSTORE  = 2'd0;
  localparam logic [2:0] NOTBRANCH = 3'd0;
  localparam logic [2:0] BJAL      = 3'd1;
  localparam logic [2:0] BJALR     = 3'd2;

  // In-flight slots
  logic             ex_v_q, mem_v_q;
  logic [REG_W-1:0] ex_dst_q, mem_dst_q;
  logic             ex_wr_q, mem_wr_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic rs1_used, rs2_used, cond_branch;
  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic stall, flush, id_ready, issue;

  // Source usage and slot matching against the decoded instruction
  always_comb begin
    cond_branch = (bus.info_branch != NOTBRANCH) && (bus.info_branch != BJAL) &&
                  (bus.info_branch != BJALR);
    rs1_used    = (bus.srcreg1_num != '0);
    rs2_used    = (bus.srcreg2_num != '0) &&
                  (bus.using_r2 || (bus.info_store != NOTSTORE) || cond_branch);
    // x0 is excluded through rs*_used
    ex_hit1     = rs1_used && ex_v_q && ex_wr_q && (ex_dst_q == bus.srcreg1_num);
    ex_hit2     = rs2_used && ex_v_q && ex_wr_q && (ex_dst_q == bus.srcreg2_num);
    mem_hit1    = rs1_used && mem_v_q && mem_wr_q && (mem_dst_q == bus.srcreg1_num);
    mem_hit2    = rs2_used && mem_v_q && mem_wr_q && (mem_dst_q == bus.srcreg2_num);
  end

`ifdef FORWARDING_EN
  logic       ex_ld_q;
  logic [1:0] fwd1_d, fwd2_d, fwd1_q, fwd2_q;

  // Load-use stall and youngest-producer forward selection
  always_comb begin
    stall  = bus.id_valid && ex_ld_q && (ex_hit1 || ex_hit2);
    fwd1_d = ex_hit1 ? 2'd1 : (mem_hit1 ? 2'd2 : 2'd0);
    fwd2_d = ex_hit2 ? 2'd1 : (mem_hit2 ? 2'd2 : 2'd0);
  end

  // Load flag and registered forward selects follow the EX slot
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      ex_ld_q <= 1'b0;
      fwd1_q  <= 2'd0;
      fwd2_q  <= 2'd0;
    end else begin
      ex_ld_q <= issue && (bus.info_load != NOTLOAD);
      fwd1_q  <= issue ? fwd1_d : 2'd0;
      fwd2_q  <= issue ? fwd2_d : 2'd0;
    end
  end

  assign bus.ex_fwd1_sel = fwd1_q;
  assign bus.ex_fwd2_sel = fwd2_q;
`else
  logic unused_info_load;

  // Without forwarding any producer still in EX or MEM blocks issue
  always_comb begin
    stall = bus.id_valid && (ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2);
  end

  assign unused_info_load = ^bus.info_load;
  assign bus.ex_fwd1_sel  = 2'd0;
  assign bus.ex_fwd2_sel  = 2'd0;
`endif

  // Flush overrides stall; a branch outcome only counts for a real EX instruction
  always_comb begin
    flush    = bus.ex_br_taken && ex_v_q;
    id_ready = !stall || flush;
    issue    = bus.id_valid && id_ready && !flush;
  end

  // Slot shift EX->MEM every cycle; EX takes the issued instruction or a bubble
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      ex_v_q    <= 1'b0;
      ex_dst_q  <= '0;
      ex_wr_q   <= 1'b0;
      mem_v_q   <= 1'b0;
      mem_dst_q <= '0;
      mem_wr_q  <= 1'b0;
    end else begin
      ex_v_q    <= issue;
      ex_dst_q  <= bus.dstreg_num;
      ex_wr_q   <= issue && bus.write_reg;
      mem_v_q   <= ex_v_q;
      mem_dst_q <= ex_dst_q;
      mem_wr_q  <= ex_wr_q;
    end
  end

  // Saturating count of cycles lost to a stall that was not flushed away
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      stall_cnt_q <= '0;
    end else if (stall && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.id_ready    = id_ready;
  assign bus.flush       = flush;
  assign bus.ex_valid    = ex_v_q;
  assign bus.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_issue_controller.sv
// Self-checking bench for issue_controller: directed RV32I sequences plus
// randomized decoder traffic, checked against a register-keyed scoreboard of
// recently issued instructions. Follows the FORWARDING_EN build option.
module tb_issue_controller;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  typedef struct {
    int         edge_n;
    logic [4:0] dst;
    logic       wr;
    logic       ld;
  } rec_t;

  logic clk;
  logic rstd;

  issue_controller_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  issue_controller #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rstd (rstd),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard state
  rec_t       q[$];
  int         edge_cnt = 0;
  logic       m_ex_valid = 1'b0;
  logic       m_issue;
  logic [1:0] m_sel1 = 2'd0, m_sel2 = 2'd0;
  int         m_count = 0;
  logic       s_ready_dut, s_flush_dut;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ex_valid = 1'b0;
    m_sel1     = 2'd0;
    m_sel2     = 2'd0;
    m_count    = 0;
  endtask

  task automatic set_idle();
    bus.id_valid    = 1'b0;
    bus.srcreg1_num = '0;
    bus.srcreg2_num = '0;
    bus.dstreg_num  = '0;
    bus.using_r2    = 1'b0;
    bus.write_reg   = 1'b0;
    bus.info_load   = 3'd0;
    bus.info_store  = 2'd0;
    bus.info_branch = 3'd0;
    bus.ex_br_taken = 1'b0;
  endtask

  // Minimal RV32I decoder producing the controller's input fields
  task automatic decode(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    bus.id_valid    = 1'b1;
    bus.srcreg1_num = ins[19:15];
    bus.srcreg2_num = ins[24:20];
    bus.dstreg_num  = ins[11:7];
    bus.using_r2    = (op == 7'b0110011);
    bus.write_reg   = (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011);
    bus.info_load   = (op == 7'b0000011) ? 3'(ins[14:12]) + 3'd1 : 3'd0;
    bus.info_store  = (op == 7'b0100011) ? ins[13:12] + 2'd1 : 2'd0;
    bus.info_branch = (op == 7'b1100011) ? 3'd3 : 3'd0;
  endtask

  // Youngest issued writer of src still in EX (age 0) or MEM (age 1), else -1
  task automatic find_producer(input logic [4:0] src, output int age, output logic ld);
    age = -1;
    ld  = 1'b0;
    if (src != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].wr && q[i].dst == src) begin
          age = edge_cnt - q[i].edge_n;
          ld  = q[i].ld;
          break;
        end
      end
    end
  endtask

  // One clock: check combinational outputs at negedge, registered ones after posedge
  task automatic step();
    int         a1, a2;
    logic       l1, l2, u1, u2, cond, stall_m, flush_m, ready_m;
    logic [1:0] s1, s2;
    @(negedge clk);
    cond = !(bus.info_branch inside {3'd0, 3'd1, 3'd2});
    u1   = bus.srcreg1_num != 0;
    u2   = bus.srcreg2_num != 0 && (bus.using_r2 || bus.info_store != 2'd0 || cond);
    find_producer(bus.srcreg1_num, a1, l1);
    find_producer(bus.srcreg2_num, a2, l2);
    if (!u1) a1 = -1;
    if (!u2) a2 = -1;
`ifdef FORWARDING_EN
    stall_m = bus.id_valid && ((a1 == 0 && l1) || (a2 == 0 && l2));
    s1 = (a1 == 0) ? 2'd1 : (a1 == 1) ? 2'd2 : 2'd0;
    s2 = (a2 == 0) ? 2'd1 : (a2 == 1) ? 2'd2 : 2'd0;
`else
    stall_m = bus.id_valid && (a1 >= 0 || a2 >= 0);
    s1 = 2'd0;
    s2 = 2'd0;
`endif
    flush_m = bus.ex_br_taken && m_ex_valid;
    ready_m = !stall_m || flush_m;
    m_issue = bus.id_valid && ready_m && !flush_m;
    s_ready_dut = bus.id_ready;
    s_flush_dut = bus.flush;
    check_eq("id_ready", bus.id_ready, ready_m);
    check_eq("flush", bus.flush, flush_m);
    @(posedge clk);
    edge_cnt++;
    if (stall_m && !flush_m && m_count < (1 << CNT_W) - 1) m_count++;
    if (m_issue)
      q.push_back('{edge_n: edge_cnt, dst: bus.dstreg_num, wr: bus.write_reg,
                    ld: bus.info_load != 3'd0});
    while (q.size() > 0 && edge_cnt - q[0].edge_n > 1) void'(q.pop_front());
    m_ex_valid = m_issue;
    m_sel1     = m_issue ? s1 : 2'd0;
    m_sel2     = m_issue ? s2 : 2'd0;
    #1;
    check_eq("ex_valid", bus.ex_valid, m_ex_valid);
    check_eq("ex_fwd1_sel", bus.ex_fwd1_sel, m_sel1);
    check_eq("ex_fwd2_sel", bus.ex_fwd2_sel, m_sel2);
    check_eq("stall_count", bus.stall_count, m_count);
  endtask

  task automatic idle(input int n);
    set_idle();
    for (int i = 0; i < n; i++) step();
  endtask

  // Present an instruction until accepted; count cycles the DUT held id_ready low
  task automatic issue_instr(input logic [31:0] ins, output int stalls);
    decode(ins);
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (!s_ready_dut) stalls++;
      if (m_issue) break;
    end
    check_eq("issue_done", m_issue, 1);
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must clear without a clock edge
  task automatic async_reset();
    #2 rstd = 1'b0;
    #1;
    check_eq("rst_ex_valid", bus.ex_valid, 0);
    check_eq("rst_fwd1", bus.ex_fwd1_sel, 0);
    check_eq("rst_fwd2", bus.ex_fwd2_sel, 0);
    check_eq("rst_count", bus.stall_count, 0);
    check_eq("rst_id_ready", bus.id_ready, 1);
    model_reset();
    #2 rstd = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int st;
    int cnt_before;
    set_idle();
    rstd = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("init_ex_valid", bus.ex_valid, 0);
    check_eq("init_count", bus.stall_count, 0);
    check_eq("init_id_ready", bus.id_ready, 1);
    rstd = 1'b1;
    idle(2);

    // ADD x12,x10,x11 then SUB x12,x12,x11
    issue_instr(32'h00b50633, st);
    issue_instr(32'h40b60633, st);
`ifdef FORWARDING_EN
    check_eq("addsub_stalls", st, 0);
    check_eq("addsub_fwd1", bus.ex_fwd1_sel, 1);
`else
    check_eq("addsub_stalls", st, 2);
    check_eq("addsub_fwd1", bus.ex_fwd1_sel, 0);
`endif
    check_eq("addsub_fwd2", bus.ex_fwd2_sel, 0);
    idle(3);

    // LW x13,0(x10) then ADD x14,x13,x11
    issue_instr(32'h00052683, st);
    issue_instr(32'h00b68733, st);
`ifdef FORWARDING_EN
    check_eq("loaduse_stalls", st, 1);
    check_eq("loaduse_fwd1", bus.ex_fwd1_sel, 2);
`else
    check_eq("loaduse_stalls", st, 2);
    check_eq("loaduse_fwd1", bus.ex_fwd1_sel, 0);
`endif
    idle(3);

    // ADDI x0,x0,-1 then ADD x1,x0,x0
    issue_instr(32'hfff00013, st);
    issue_instr(32'h000000b3, st);
    check_eq("x0_stalls", st, 0);
    check_eq("x0_fwd1", bus.ex_fwd1_sel, 0);
    check_eq("x0_fwd2", bus.ex_fwd2_sel, 0);
    idle(3);

    // ADD x11,x10,x10 then SW x11,0(x10)
    issue_instr(32'h00a505b3, st);
    issue_instr(32'h00b52023, st);
`ifdef FORWARDING_EN
    check_eq("store_fwd2", bus.ex_fwd2_sel, 1);
    check_eq("store_fwd1", bus.ex_fwd1_sel, 0);
`else
    check_eq("store_stalls", st, 2);
`endif
    idle(3);

    // LW x13, BEQ x11,x12 taken in EX while ADD x14,x13,x11 waits in ID
    issue_instr(32'h00052683, st);
    issue_instr(32'hfec584e3, st);
    decode(32'h00b68733);
    bus.ex_br_taken = 1'b1;
    cnt_before = m_count;
    step();
    check_eq("br_flush", s_flush_dut, 1);
    check_eq("br_id_ready", s_ready_dut, 1);
    check_eq("br_ex_valid", bus.ex_valid, 0);
    check_eq("br_count", bus.stall_count, cnt_before);
    idle(3);

    // Build up stalls, then reset with a live EX slot
    for (int k = 0; k < 3; k++) begin
      issue_instr(32'h00052683, st);
      issue_instr(32'h00b68733, st);
    end
    check_eq("pre_rst_ex_valid", bus.ex_valid, 1);
    decode(32'h00b68733);
    async_reset();
    idle(2);

    // Randomized decoder traffic
    for (int n = 0; n < 3000; n++) begin
      bus.id_valid    = ($urandom_range(0, 9) < 8);
      bus.srcreg1_num = 5'($urandom_range(0, 3));
      bus.srcreg2_num = 5'($urandom_range(0, 3));
      bus.dstreg_num  = 5'($urandom_range(0, 3));
      bus.using_r2    = 1'($urandom_range(0, 1));
      bus.write_reg   = ($urandom_range(0, 3) != 0);
      bus.info_load   = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 5));
      bus.info_store  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      bus.info_branch = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      bus.ex_br_taken = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 599) == 0) async_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
